// File: rtl/wb_retire_queue_pkg.sv
// ---------------------------------------------------------------------------
// wb_retire_queue_pkg
//    Shared definitions for the writeback retire queue and its consumers.
//    ms_to_ws_bus_wd : width of the MEM->WB bus {pc, ex, gr_we, dest, result},
//                      computed from the PC_W/AW/DW parameters of the
//                      module that uses it.
//    ws_to_rf_bus_wd : width of a packed {rf_we, rf_waddr, rf_wdata} bundle.
//    Field offset helpers place result in the LSBs and pc in the MSBs.
// ---------------------------------------------------------------------------
package wb_retire_queue_pkg;

   localparam int DEF_PC_W  = 32;
   localparam int DEF_AW    = 5;
   localparam int DEF_DW    = 32;
   localparam int DEF_DEPTH = 2;

   // Bus widths shared between MEM, WB and RF consumers.
   function automatic int ms_to_ws_bus_wd(input int pc_w, input int aw, input int dw);
      return pc_w + aw + dw + 2;
   endfunction

   function automatic int ws_to_rf_bus_wd(input int aw, input int dw);
      return 1 + aw + dw;
   endfunction

   // Bit offsets of each field inside the MEM->WB bus.
   function automatic int ms_off_result();
      return 0;
   endfunction

   function automatic int ms_off_dest(input int dw);
      return dw;
   endfunction

   function automatic int ms_off_gr_we(input int aw, input int dw);
      return dw + aw;
   endfunction

   function automatic int ms_off_ex(input int aw, input int dw);
      return dw + aw + 1;
   endfunction

   function automatic int ms_off_pc(input int aw, input int dw);
      return dw + aw + 2;
   endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// ---------------------------------------------------------------------------
// wb_fwd_match
//    Finds the newest in-flight queue entry that will write register rs.
//    Entries arrive already ordered by age: index 0 is the oldest (head),
//    index DEPTH-1 the youngest slot.
//    valid  : entry k is occupied
//    wen    : entry k will really write the RF (gr_we & ~ex)
//    dest   : destination index per entry
//    result : result data per entry
//    rs     : source register being looked up
//    hit    : some valid writing entry targets rs (never for r0)
//    data   : result of the newest such entry, 0 when no hit
// ---------------------------------------------------------------------------
module wb_fwd_match
   import wb_retire_queue_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic [DEPTH-1:0] valid,
   input  logic [DEPTH-1:0] wen,
   input  logic [AW-1:0]    dest   [DEPTH],
   input  logic [DW-1:0]    result [DEPTH],
   input  logic [AW-1:0]    rs,
   output logic             hit,
   output logic [DW-1:0]    data
);

   // Walking from oldest to youngest and letting each later match overwrite
   // the earlier one gives the same answer as a newest-first priority scan.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (valid[k] && wen[k] && (dest[k] == rs) && (rs != '0)) begin
            hit  = 1'b1;
            data = result[k];
         end
      end
   end

endmodule

// File: rtl/wb_retire_queue.sv
// ---------------------------------------------------------------------------
// wb_retire_queue
//    Writeback stage with a DEPTH-entry retire FIFO between MEM and the RF
//    write port. The head retires whenever rf_ready is high; an excepting
//    head flushes the whole queue instead of writing. In-flight entries are
//    forwarded to ID on two independent source ports.
//    clk, resetn          : clock, synchronous active-low reset
//    ms_to_ws_valid/bus   : incoming instruction {pc, ex, gr_we, dest, result}
//    ws_allowin           : queue can accept an instruction this cycle
//    rf_ready             : RF port grants the head this cycle
//    rf_we/waddr/wdata    : RF write port
//    ws_flush             : excepting head retiring this cycle
//    fwd_rs*/hit*/data*   : forwarding lookups for ID
//    debug_wb_*           : trace of the retiring instruction
// ---------------------------------------------------------------------------
module wb_retire_queue
   import wb_retire_queue_pkg::*;
#(
   parameter int PC_W  = DEF_PC_W,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                                      clk,
   input  logic                                      resetn,
   input  logic                                      ms_to_ws_valid,
   input  logic [ms_to_ws_bus_wd(PC_W, AW, DW)-1:0]  ms_to_ws_bus,
   output logic                                      ws_allowin,
   input  logic                                      rf_ready,
   output logic                                      rf_we,
   output logic [AW-1:0]                             rf_waddr,
   output logic [DW-1:0]                             rf_wdata,
   output logic                                      ws_flush,
   input  logic [AW-1:0]                             fwd_rs1,
   input  logic [AW-1:0]                             fwd_rs2,
   output logic                                      fwd_hit1,
   output logic                                      fwd_hit2,
   output logic [DW-1:0]                             fwd_data1,
   output logic [DW-1:0]                             fwd_data2,
   output logic [PC_W-1:0]                           debug_wb_pc,
   output logic [3:0]                                debug_wb_rf_we,
   output logic [AW-1:0]                             debug_wb_rf_wnum,
   output logic [DW-1:0]                             debug_wb_rf_wdata
);

   localparam int PW         = $clog2(DEPTH);
   localparam int CW         = $clog2(DEPTH + 1);
   localparam int RFBW       = ws_to_rf_bus_wd(AW, DW);
   localparam int OFF_RESULT = ms_off_result();
   localparam int OFF_DEST   = ms_off_dest(DW);
   localparam int OFF_GR_WE  = ms_off_gr_we(AW, DW);
   localparam int OFF_EX     = ms_off_ex(AW, DW);
   localparam int OFF_PC     = ms_off_pc(AW, DW);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [PC_W-1:0] pc_q     [DEPTH];
   logic            ex_q     [DEPTH];
   logic            we_q     [DEPTH];
   logic [AW-1:0]   dest_q   [DEPTH];
   logic [DW-1:0]   result_q [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic retire;
   logic enq;

   logic [PC_W-1:0] in_pc;
   logic            in_ex;
   logic            in_we;
   logic [AW-1:0]   in_dest;
   logic [DW-1:0]   in_result;

   logic [RFBW-1:0] ws_to_rf_bus;

   logic [DEPTH-1:0] age_valid;
   logic [DEPTH-1:0] age_wen;
   logic [AW-1:0]    age_dest   [DEPTH];
   logic [DW-1:0]    age_result [DEPTH];

   assign in_pc     = ms_to_ws_bus[OFF_PC +: PC_W];
   assign in_ex     = ms_to_ws_bus[OFF_EX];
   assign in_we     = ms_to_ws_bus[OFF_GR_WE];
   assign in_dest   = ms_to_ws_bus[OFF_DEST +: AW];
   assign in_result = ms_to_ws_bus[OFF_RESULT +: DW];

   // Handshake. A flushing cycle refuses new input so nothing younger than
   // the exception can slip in while the queue is being emptied.
   assign retire     = (count != '0) & rf_ready;
   assign ws_flush   = retire & ex_q[head];
   assign ws_allowin = ~ws_flush & ((count < DEPTH_C) | retire);
   assign enq        = ms_to_ws_valid & ws_allowin;

   // Pointer and occupancy bookkeeping. Pointers are exactly clog2(DEPTH)
   // bits wide, so incrementing them wraps modulo DEPTH on its own.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (ws_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            tail <= tail + PW'(1);
         end
         if (retire) begin
            head <= head + PW'(1);
         end
         if (enq && !retire) begin
            count <= count + CW'(1);
         end else if (retire && !enq) begin
            count <= count - CW'(1);
         end
      end
   end

   // Entry payloads carry no reset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_q[tail]     <= in_pc;
         ex_q[tail]     <= in_ex;
         we_q[tail]     <= in_we;
         dest_q[tail]   <= in_dest;
         result_q[tail] <= in_result;
      end
   end

   // Retire-side outputs, all forced to zero unless the head leaves now.
   // An excepting head still shows its dest/result but never writes.
   assign ws_to_rf_bus = retire ? {we_q[head] & ~ex_q[head], dest_q[head], result_q[head]}
                                : '0;
   assign rf_we             = ws_to_rf_bus[AW+DW];
   assign rf_waddr          = ws_to_rf_bus[DW +: AW];
   assign rf_wdata          = ws_to_rf_bus[DW-1:0];
   assign debug_wb_pc       = retire ? pc_q[head] : '0;
   assign debug_wb_rf_we    = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

   // Present the storage to the matchers rotated so that index 0 is the
   // head; the first count positions are the live entries.
   always_comb begin
      age_valid = '0;
      age_wen   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         age_valid[k]  = CW'(k) < count;
         age_wen[k]    = we_q[head + PW'(k)] & ~ex_q[head + PW'(k)];
         age_dest[k]   = dest_q[head + PW'(k)];
         age_result[k] = result_q[head + PW'(k)];
      end
   end

   wb_fwd_match #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fwd1 (
      .valid  (age_valid),
      .wen    (age_wen),
      .dest   (age_dest),
      .result (age_result),
      .rs     (fwd_rs1),
      .hit    (fwd_hit1),
      .data   (fwd_data1)
   );

   wb_fwd_match #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fwd2 (
      .valid  (age_valid),
      .wen    (age_wen),
      .dest   (age_dest),
      .result (age_result),
      .rs     (fwd_rs2),
      .hit    (fwd_hit2),
      .data   (fwd_data2)
   );

endmodule

// File: tb/tb_wb_retire_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_retire_queue
//    Drives a DEPTH=2 and a DEPTH=4 instance of wb_retire_queue from the same
//    inputs. A queue-based model predicts every output of both; a hand-built
//    vector table additionally pins down the DEPTH=2 instance.
// ---------------------------------------------------------------------------
module tb_wb_retire_queue;

   localparam int PC_W = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int BW   = PC_W + AW + DW + 2;

   typedef struct {
      logic [31:0] pc;
      logic        ex;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] res;
   } ent_t;

   typedef ent_t ent_q_t [$];

   typedef struct {
      logic        allow;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        flush;
      logic [31:0] pc;
      logic        hit1;
      logic [31:0] d1;
      logic        hit2;
      logic [31:0] d2;
   } exp_t;

   typedef struct {
      logic       rstn;
      logic       valid;
      logic       ready;
      ent_t       ent;
      logic [4:0] rs1;
      logic [4:0] rs2;
      exp_t       exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic          ms_valid;
   logic [BW-1:0] ms_bus;
   logic          rf_ready;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic [31:0]   in_pc;
   logic          in_ex;
   logic          in_we;
   logic [4:0]    in_dest;
   logic [31:0]   in_res;

   logic            d2_allowin, d2_rf_we, d2_flush, d2_hit1, d2_hit2;
   logic [AW-1:0]   d2_waddr, d2_wnum;
   logic [DW-1:0]   d2_wdata, d2_data1, d2_data2, d2_dbg_wdata;
   logic [PC_W-1:0] d2_pc;
   logic [3:0]      d2_dbg_we;

   logic            d4_allowin, d4_rf_we, d4_flush, d4_hit1, d4_hit2;
   logic [AW-1:0]   d4_waddr, d4_wnum;
   logic [DW-1:0]   d4_wdata, d4_data1, d4_data2, d4_dbg_wdata;
   logic [PC_W-1:0] d4_pc;
   logic [3:0]      d4_dbg_we;

   int vectors     = 0;
   int miscompares = 0;

   ent_q_t mq2;
   ent_q_t mq4;
   vec_t   tbl [$];

   assign ms_bus = {in_pc, in_ex, in_we, in_dest, in_res};

   always #5 clk = ~clk;

   wb_retire_queue #(.PC_W(PC_W), .AW(AW), .DW(DW), .DEPTH(2)) dut2 (
      .clk               (clk),
      .resetn            (resetn),
      .ms_to_ws_valid    (ms_valid),
      .ms_to_ws_bus      (ms_bus),
      .ws_allowin        (d2_allowin),
      .rf_ready          (rf_ready),
      .rf_we             (d2_rf_we),
      .rf_waddr          (d2_waddr),
      .rf_wdata          (d2_wdata),
      .ws_flush          (d2_flush),
      .fwd_rs1           (rs1),
      .fwd_rs2           (rs2),
      .fwd_hit1          (d2_hit1),
      .fwd_hit2          (d2_hit2),
      .fwd_data1         (d2_data1),
      .fwd_data2         (d2_data2),
      .debug_wb_pc       (d2_pc),
      .debug_wb_rf_we    (d2_dbg_we),
      .debug_wb_rf_wnum  (d2_wnum),
      .debug_wb_rf_wdata (d2_dbg_wdata)
   );

   wb_retire_queue #(.PC_W(PC_W), .AW(AW), .DW(DW), .DEPTH(4)) dut4 (
      .clk               (clk),
      .resetn            (resetn),
      .ms_to_ws_valid    (ms_valid),
      .ms_to_ws_bus      (ms_bus),
      .ws_allowin        (d4_allowin),
      .rf_ready          (rf_ready),
      .rf_we             (d4_rf_we),
      .rf_waddr          (d4_waddr),
      .rf_wdata          (d4_wdata),
      .ws_flush          (d4_flush),
      .fwd_rs1           (rs1),
      .fwd_rs2           (rs2),
      .fwd_hit1          (d4_hit1),
      .fwd_hit2          (d4_hit2),
      .fwd_data1         (d4_data1),
      .fwd_data2         (d4_data2),
      .debug_wb_pc       (d4_pc),
      .debug_wb_rf_we    (d4_dbg_we),
      .debug_wb_rf_wnum  (d4_wnum),
      .debug_wb_rf_wdata (d4_dbg_wdata)
   );

   // Newest valid writing entry for rs, scanning the model queue from the back.
   function automatic logic [32:0] modelFwd(input ent_q_t q, input logic [4:0] rs);
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].we && !q[i].ex && q[i].dest == rs && rs != 5'd0) begin
            return {1'b1, q[i].res};
         end
      end
      return 33'd0;
   endfunction

   // Expected outputs for the current cycle from queue contents and inputs.
   function automatic exp_t modelOut(input ent_q_t q, input int depth, input vec_t v);
      exp_t        e;
      logic        ret;
      logic [32:0] f;
      e     = '{default: '0};
      ret   = (q.size() != 0) && v.ready;
      if (ret) begin
         e.we    = q[0].we && !q[0].ex;
         e.waddr = q[0].dest;
         e.wdata = q[0].res;
         e.flush = q[0].ex;
         e.pc    = q[0].pc;
      end
      e.allow = !e.flush && ((q.size() < depth) || ret);
      f       = modelFwd(q, v.rs1);
      e.hit1  = f[32];
      e.d1    = f[31:0];
      f       = modelFwd(q, v.rs2);
      e.hit2  = f[32];
      e.d2    = f[31:0];
      return e;
   endfunction

   // Queue contents after the clock edge.
   function automatic ent_q_t modelNext(input ent_q_t q, input int depth, input vec_t v);
      ent_q_t r;
      exp_t   e;
      r = q;
      if (!v.rstn) begin
         r.delete();
         return r;
      end
      e = modelOut(q, depth, v);
      if (e.flush) begin
         r.delete();
      end else begin
         if (q.size() != 0 && v.ready) begin
            void'(r.pop_front());
         end
         if (v.valid && e.allow) begin
            r.push_back(v.ent);
         end
      end
      return r;
   endfunction

   function automatic vec_t mk(
      input logic rstn, input logic valid, input logic [31:0] pc, input logic ex,
      input logic we, input logic [4:0] dest, input logic [31:0] res, input logic ready,
      input logic [4:0] r1, input logic [4:0] r2,
      input logic e_allow, input logic e_we, input logic [4:0] e_waddr,
      input logic [31:0] e_wdata, input logic e_flush, input logic [31:0] e_pc,
      input logic e_hit1, input logic [31:0] e_d1, input logic e_hit2, input logic [31:0] e_d2);
      vec_t v;
      v.rstn      = rstn;
      v.valid     = valid;
      v.ready     = ready;
      v.ent       = '{pc: pc, ex: ex, we: we, dest: dest, res: res};
      v.rs1       = r1;
      v.rs2       = r2;
      v.exp       = '{allow: e_allow, we: e_we, waddr: e_waddr, wdata: e_wdata, flush: e_flush,
                      pc: e_pc, hit1: e_hit1, d1: e_d1, hit2: e_hit2, d2: e_d2};
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      resetn   = v.rstn;
      ms_valid = v.valid;
      rf_ready = v.ready;
      in_pc    = v.ent.pc;
      in_ex    = v.ent.ex;
      in_we    = v.ent.we;
      in_dest  = v.ent.dest;
      in_res   = v.ent.res;
      rs1      = v.rs1;
      rs2      = v.rs2;
   endtask

   task automatic checkOutput(input string tag, input int depth, input exp_t e);
      if (depth == 2) begin
         cmp({tag, ".allowin"}, 32'(d2_allowin), 32'(e.allow));
         cmp({tag, ".rf_we"},   32'(d2_rf_we),   32'(e.we));
         cmp({tag, ".waddr"},   32'(d2_waddr),   32'(e.waddr));
         cmp({tag, ".wdata"},   d2_wdata,        e.wdata);
         cmp({tag, ".flush"},   32'(d2_flush),   32'(e.flush));
         cmp({tag, ".dbg_pc"},  d2_pc,           e.pc);
         cmp({tag, ".dbg_we"},  32'(d2_dbg_we),  32'({4{e.we}}));
         cmp({tag, ".dbg_num"}, 32'(d2_wnum),    32'(e.waddr));
         cmp({tag, ".dbg_dat"}, d2_dbg_wdata,    e.wdata);
         cmp({tag, ".hit1"},    32'(d2_hit1),    32'(e.hit1));
         cmp({tag, ".data1"},   d2_data1,        e.d1);
         cmp({tag, ".hit2"},    32'(d2_hit2),    32'(e.hit2));
         cmp({tag, ".data2"},   d2_data2,        e.d2);
      end else begin
         cmp({tag, ".allowin"}, 32'(d4_allowin), 32'(e.allow));
         cmp({tag, ".rf_we"},   32'(d4_rf_we),   32'(e.we));
         cmp({tag, ".waddr"},   32'(d4_waddr),   32'(e.waddr));
         cmp({tag, ".wdata"},   d4_wdata,        e.wdata);
         cmp({tag, ".flush"},   32'(d4_flush),   32'(e.flush));
         cmp({tag, ".dbg_pc"},  d4_pc,           e.pc);
         cmp({tag, ".dbg_we"},  32'(d4_dbg_we),  32'({4{e.we}}));
         cmp({tag, ".dbg_num"}, 32'(d4_wnum),    32'(e.waddr));
         cmp({tag, ".dbg_dat"}, d4_dbg_wdata,    e.wdata);
         cmp({tag, ".hit1"},    32'(d4_hit1),    32'(e.hit1));
         cmp({tag, ".data1"},   d4_data1,        e.d1);
         cmp({tag, ".hit2"},    32'(d4_hit2),    32'(e.hit2));
         cmp({tag, ".data2"},   d4_data2,        e.d2);
      end
   endtask

   // One clock: drive, check mid-cycle against the model (and the table row
   // when given), then advance the model across the edge.
   task automatic runCycle(input vec_t v, input bit use_table, input string tag);
      applyStimulus(v);
      @(negedge clk);
      checkOutput({tag, ".m2"}, 2, modelOut(mq2, 2, v));
      checkOutput({tag, ".m4"}, 4, modelOut(mq4, 4, v));
      if (use_table) begin
         checkOutput({tag, ".tbl"}, 2, v.exp);
      end
      mq2 = modelNext(mq2, 2, v);
      mq4 = modelNext(mq4, 4, v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;

      // rstn vld pc          ex we dst res   rdy rs1 rs2 | allow we waddr wdata flush pc        h1 d1   h2 d2
      tbl.push_back(mk(0,1,32'h100,      0,1,1,32'h99, 1,1,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(0,1,32'h100,      0,1,1,32'h99, 1,1,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(0,1,32'h100,      0,1,1,32'h99, 1,1,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,1,32'h1c000000, 0,1,5,32'h11, 1,5,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,1,32'h1c000004, 0,1,6,32'h22, 1,5,6, 1,1,5,32'h11,0,32'h1c000000,1,32'h11,0,0));
      tbl.push_back(mk(1,1,32'h1c000008, 0,1,7,32'h33, 1,6,5, 1,1,6,32'h22,0,32'h1c000004,1,32'h22,0,0));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      1,7,0, 1,1,7,32'h33,0,32'h1c000008,1,32'h33,0,0));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      1,7,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,1,32'h200,      0,1,4,32'hA,  0,4,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,1,32'h204,      0,1,4,32'hB,  0,4,0, 1,0,0,0,    0,0,            1,32'hA,0,0));
      tbl.push_back(mk(1,1,32'h208,      0,1,9,32'hC,  0,4,0, 0,0,0,0,    0,0,            1,32'hB,0,0));
      tbl.push_back(mk(1,1,32'h208,      0,1,9,32'hC,  1,4,9, 1,1,4,32'hA,0,32'h200,      1,32'hB,0,0));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      0,9,4, 0,0,0,0,    0,0,            1,32'hC,1,32'hB));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      1,4,9, 1,1,4,32'hB,0,32'h204,      1,32'hB,1,32'hC));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      1,9,0, 1,1,9,32'hC,0,32'h208,      1,32'hC,0,0));
      tbl.push_back(mk(1,1,32'h300,      1,1,3,32'hE,  0,3,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,1,32'h304,      0,1,3,32'hF,  0,3,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,1,32'h308,      0,1,8,32'h10, 1,3,8, 0,0,3,32'hE,1,32'h300,      1,32'hF,0,0));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      1,3,8, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,1,32'h400,      0,1,0,32'h55, 0,0,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      1,0,0, 1,1,0,32'h55,0,32'h400,     0,0,    0,0));
      tbl.push_back(mk(1,1,32'h500,      0,0,2,32'h66, 1,2,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      1,2,0, 1,0,2,32'h66,0,32'h500,     0,0,    0,0));
      tbl.push_back(mk(1,1,32'h600,      0,1,1,32'h1,  0,1,0, 1,0,0,0,    0,0,            0,0,    0,0));
      tbl.push_back(mk(0,0,0,            0,0,0,0,      0,1,0, 1,0,0,0,    0,0,            1,32'h1,0,0));
      tbl.push_back(mk(1,0,0,            0,0,0,0,      1,1,0, 1,0,0,0,    0,0,            0,0,    0,0));

      // Both queues start from a reset edge so the model's empty queues match.
      v = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0);
      applyStimulus(v);
      @(posedge clk);
      #1;

      $display("[TB] directed table: %0d rows", tbl.size());
      for (int i = 0; i < tbl.size(); i++) begin
         runCycle(tbl[i], 1'b1, $sformatf("row%0d", i));
      end

      // Five back-to-back enqueue/retire pairs; the DEPTH=4 pointers wrap.
      for (int i = 0; i < 6; i++) begin
         v = mk(1, (i < 5), 32'h700 + 32'(4 * i), 0, 1, 5'(10 + i), 32'(i * 16 + 1), 1,
                5'(9 + i), 5'(10 + i), 0,0,0,0,0,0,0,0,0,0);
         runCycle(v, 1'b0, $sformatf("wrap%0d", i));
      end

      // Partly-filled DEPTH=4 queue streaming with stalls to exercise wrap at
      // higher occupancy.
      for (int i = 0; i < 12; i++) begin
         v = mk(1, 1, 32'h800 + 32'(4 * i), 0, 1, 5'(1 + (i % 6)), 32'(32'h1000 + i),
                (i % 3 != 0), 5'(1 + (i % 6)), 5'(1 + ((i + 2) % 6)), 0,0,0,0,0,0,0,0,0,0);
         runCycle(v, 1'b0, $sformatf("fill%0d", i));
      end

      $display("[TB] randomized phase");
      for (int i = 0; i < 3000; i++) begin
         v = mk(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 7),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                0,0,0,0,0,0,0,0,0,0);
         runCycle(v, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
